memory_stage: RTL and testbench

Pipeline MEM stage, directly downstream of the execute stage. Captures the execute-stage results into an EX/MEM register and performs the load or store through a ready-based data-memory handshake. Stalls the upstream pipeline while an access is outstanding. Presents registered MEM/WB results (write-back data, destination register, write enable) to write-back, and exposes the EX/MEM register contents for forwarding into execute.

---
 rtl/memory_stage_if.sv | 19 +
 rtl/memory_stage.sv | 143 ++++++++++++++
 tb/tb_memory_stage.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_if.sv
// Data-memory request/response bus between the MEM stage and data memory.
interface memory_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/memory_stage.sv
// Pipeline MEM stage: EX/MEM register, ready-based data-memory access with
// wait-cycle timeout, upstream stall, and registered MEM/WB results.
module memory_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [63:0]        ALUResult_EX,
    input  logic [63:0]        RdData2_EX,
    input  logic [4:0]         Rd_EX,
    input  logic               MemWrite_EX,
    input  logic               MemToReg_EX,
    input  logic               RegWrite_EX,
    input  logic               valid_EX,
    output logic               stall_MEM,
    memory_stage_if.master     mem,
    output logic [63:0]        ALUResult_MEMREG,
    output logic [4:0]         Rd_MEMREG,
    output logic               RegWrite_MEMREG,
    output logic [63:0]        WrData_MEM,
    output logic [4:0]         Rd_MEM,
    output logic               RegWrite_MEM,
    output logic               valid_MEM,
    output logic               fault_MEM
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, next_state;
    logic [7:0]  wait_cnt;

    // EX/MEM register contents
    logic [63:0] alu_p0;
    logic [63:0] rd2_p0;
    logic [4:0]  rd_p0;
    logic        mw_p0;
    logic        m2r_p0;
    logic        rw_p0;
    logic        vld_p0;

    logic        is_mem_p0;
    logic        misaligned_p0;
    logic        timeout;
    logic        fault;
    logic        ex_aligned_mem;
    logic [63:0] wb_data;

    // Next state, handshake outputs, stall and completion result
    always_comb begin
        next_state     = state;
        stall_MEM      = 1'b0;
        timeout        = 1'b0;
        mem.mem_req    = 1'b0;
        mem.mem_we     = 1'b0;
        mem.mem_addr   = alu_p0;
        mem.mem_wdata  = rd2_p0;
        is_mem_p0      = vld_p0 & (mw_p0 | m2r_p0);
        misaligned_p0  = is_mem_p0 & (alu_p0[2:0] != 3'b000);
        ex_aligned_mem = valid_EX & (MemWrite_EX | MemToReg_EX) &
                         (ALUResult_EX[2:0] == 3'b000);

        if (state == S_WAIT) begin
            mem.mem_req = 1'b1;
            mem.mem_we  = mw_p0;
            timeout     = !mem.mem_ready && (wait_cnt == CNT_LAST);
            stall_MEM   = !mem.mem_ready && !timeout;
        end

        // Every non-stalled edge completes R and reloads it from EX
        if (!stall_MEM) begin
            next_state = ex_aligned_mem ? S_WAIT : S_IDLE;
        end

        fault = misaligned_p0 | timeout;
        if (fault) begin
            wb_data = 64'd0;
        end else if (m2r_p0) begin
            wb_data = mem.mem_rdata;
        end else begin
            wb_data = alu_p0;
        end
    end

    // State register and wait-cycle counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state    <= next_state;
            wait_cnt <= stall_MEM ? wait_cnt + 8'd1 : 8'd0;
        end
    end

    // EX/MEM register: loads whenever the stage is not stalled
    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_p0 <= 64'd0;
            rd2_p0 <= 64'd0;
            rd_p0  <= 5'd0;
            mw_p0  <= 1'b0;
            m2r_p0 <= 1'b0;
            rw_p0  <= 1'b0;
            vld_p0 <= 1'b0;
        end else if (!stall_MEM) begin
            alu_p0 <= ALUResult_EX;
            rd2_p0 <= RdData2_EX;
            rd_p0  <= Rd_EX;
            mw_p0  <= MemWrite_EX;
            m2r_p0 <= MemToReg_EX;
            rw_p0  <= RegWrite_EX;
            vld_p0 <= valid_EX;
        end
    end

    // MEM/WB register: retires R on completion, inserts a bubble while stalled
    always_ff @(posedge clk) begin
        if (!reset) begin
            WrData_MEM   <= 64'd0;
            Rd_MEM       <= 5'd0;
            RegWrite_MEM <= 1'b0;
            valid_MEM    <= 1'b0;
            fault_MEM    <= 1'b0;
        end else if (stall_MEM) begin
            RegWrite_MEM <= 1'b0;
            valid_MEM    <= 1'b0;
            fault_MEM    <= 1'b0;
        end else begin
            WrData_MEM   <= wb_data;
            Rd_MEM       <= rd_p0;
            RegWrite_MEM <= rw_p0 & vld_p0 & !fault;
            valid_MEM    <= vld_p0;
            fault_MEM    <= fault;
        end
    end

    assign ALUResult_MEMREG = alu_p0;
    assign Rd_MEMREG        = rd_p0;
    assign RegWrite_MEMREG  = rw_p0 & vld_p0;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: random instruction stream, a behavioural
// data memory with per-access latency, and a write-back monitor.
module tb_memory_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] ALUResult_EX = '0;
    logic [63:0] RdData2_EX = '0;
    logic [4:0]  Rd_EX = '0;
    logic        MemWrite_EX = 1'b0;
    logic        MemToReg_EX = 1'b0;
    logic        RegWrite_EX = 1'b0;
    logic        valid_EX = 1'b0;
    logic        stall_MEM;
    logic [63:0] ALUResult_MEMREG;
    logic [4:0]  Rd_MEMREG;
    logic        RegWrite_MEMREG;
    logic [63:0] WrData_MEM;
    logic [4:0]  Rd_MEM;
    logic        RegWrite_MEM;
    logic        valid_MEM;
    logic        fault_MEM;

    memory_stage_if mif();

    memory_stage #(.TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .ALUResult_EX     (ALUResult_EX),
        .RdData2_EX       (RdData2_EX),
        .Rd_EX            (Rd_EX),
        .MemWrite_EX      (MemWrite_EX),
        .MemToReg_EX      (MemToReg_EX),
        .RegWrite_EX      (RegWrite_EX),
        .valid_EX         (valid_EX),
        .stall_MEM        (stall_MEM),
        .mem              (mif),
        .ALUResult_MEMREG (ALUResult_MEMREG),
        .Rd_MEMREG        (Rd_MEMREG),
        .RegWrite_MEMREG  (RegWrite_MEMREG),
        .WrData_MEM       (WrData_MEM),
        .Rd_MEM           (Rd_MEM),
        .RegWrite_MEM     (RegWrite_MEM),
        .valid_MEM        (valid_MEM),
        .fault_MEM        (fault_MEM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] wr;
        logic [4:0]  rd;
        logic        rw;
        logic        flt;
        int          cyc;
    } res_t;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        int          lat;
    } req_t;

    res_t        res_q[$];
    req_t        req_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [63:0] model_mem[32];
    logic [63:0] dev_mem[32];

    // Previously accepted instruction, expected in the EX/MEM register
    logic        have_prev = 1'b0;
    logic [63:0] prev_alu;
    logic [4:0]  prev_rd;
    logic        prev_rwv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Write-back monitor
    always @(negedge clk) begin : monitor
        res_t r;
        if (reset) begin
            if (valid_MEM) begin
                if (res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got valid_MEM=1 expected no result (cycle %0d)", cyc);
                end else begin
                    r = res_q.pop_front();
                    chk("wb_cycle", 64'(cyc), 64'(r.cyc));
                    chk("wb_data", WrData_MEM, r.wr);
                    chk("wb_rd", 64'(Rd_MEM), 64'(r.rd));
                    chk("wb_regwrite", 64'(RegWrite_MEM), 64'(r.rw));
                    chk("wb_fault", 64'(fault_MEM), 64'(r.flt));
                end
            end else begin
                chk("bubble_regwrite", 64'(RegWrite_MEM), 64'd0);
                chk("bubble_fault", 64'(fault_MEM), 64'd0);
            end
        end
    end

    // Data memory: latency per access taken from the expected-request queue
    always @(posedge clk) begin : responder
        static logic busy = 1'b0;
        static int   waited = 0;
        req_t        cur;
        #1;
        if (!reset || !mif.mem_req) begin
            busy          = 1'b0;
            mif.mem_ready = ($urandom_range(0, 3) == 0);
            mif.mem_rdata = {$urandom, $urandom};
        end else begin
            if (!busy) begin
                busy   = 1'b1;
                waited = 0;
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_request: got request at %0h expected none", mif.mem_addr);
                    cur.addr  = mif.mem_addr;
                    cur.we    = mif.mem_we;
                    cur.wdata = mif.mem_wdata;
                    cur.lat   = 0;
                end else begin
                    cur = req_q.pop_front();
                end
            end
            chk("req_addr", mif.mem_addr, cur.addr);
            chk("req_we", 64'(mif.mem_we), 64'(cur.we));
            if (cur.we) chk("req_wdata", mif.mem_wdata, cur.wdata);
            mif.mem_ready = (waited >= cur.lat);
            mif.mem_rdata = mif.mem_ready ? dev_mem[mif.mem_addr[7:3]] : {$urandom, $urandom};
            if (mif.mem_ready && mif.mem_we) dev_mem[mif.mem_addr[7:3]] = mif.mem_wdata;
            waited++;
            if (mif.mem_ready || waited == TO) busy = 1'b0;
        end
    end

    // Present one instruction, wait until accepted, and record its expected outcome
    task automatic issue(input logic [63:0] alu, input logic [63:0] d2, input logic [4:0] rd,
                         input logic mw, input logic m2r, input logic rw, input logic v,
                         input int lat);
        logic accepted = 1'b0;
        logic is_mem, misal, tmo, flt;
        int   d;
        res_t r;
        req_t q;
        ALUResult_EX = alu;
        RdData2_EX   = d2;
        Rd_EX        = rd;
        MemWrite_EX  = mw;
        MemToReg_EX  = m2r;
        RegWrite_EX  = rw;
        valid_EX     = v;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k == 0 && have_prev) begin
                chk("fwd_alu", ALUResult_MEMREG, prev_alu);
                chk("fwd_rd", 64'(Rd_MEMREG), 64'(prev_rd));
                chk("fwd_regwrite", 64'(RegWrite_MEMREG), 64'(prev_rwv));
            end
            if (!stall_MEM) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            $display("FAIL stall_bound: got stall held 64 cycles expected release");
            $fatal(1, "stage never accepted an instruction");
        end
        is_mem = v && (mw || m2r);
        misal  = is_mem && (alu[2:0] != 3'b000);
        tmo    = is_mem && !misal && (lat >= TO);
        flt    = misal || tmo;
        d      = (is_mem && !misal) ? ((lat < TO) ? lat : TO - 1) : 0;
        if (is_mem && !misal) begin
            q.addr  = alu;
            q.we    = mw;
            q.wdata = d2;
            q.lat   = lat;
            req_q.push_back(q);
        end
        if (v) begin
            r.rd  = rd;
            r.rw  = rw && !flt;
            r.flt = flt;
            r.cyc = cyc + 2 + d;
            if (flt)      r.wr = 64'd0;
            else if (m2r) r.wr = model_mem[alu[7:3]];
            else          r.wr = alu;
            res_q.push_back(r);
            if (is_mem && !flt && mw) model_mem[alu[7:3]] = d2;
        end
        have_prev = 1'b1;
        prev_alu  = alu;
        prev_rd   = rd;
        prev_rwv  = rw && v;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        valid_EX = 1'b0;
        for (int k = 0; k < 60 && res_q.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain_results_left", 64'(res_q.size()), 64'd0);
        chk("drain_requests_left", 64'(req_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"}, 64'(stall_MEM), 64'd0);
        chk({tag, "_req"}, 64'(mif.mem_req), 64'd0);
        chk({tag, "_we"}, 64'(mif.mem_we), 64'd0);
        chk({tag, "_addr"}, mif.mem_addr, 64'd0);
        chk({tag, "_wdata"}, mif.mem_wdata, 64'd0);
        chk({tag, "_fwd_alu"}, ALUResult_MEMREG, 64'd0);
        chk({tag, "_fwd_rd"}, 64'(Rd_MEMREG), 64'd0);
        chk({tag, "_fwd_rw"}, 64'(RegWrite_MEMREG), 64'd0);
        chk({tag, "_wrdata"}, WrData_MEM, 64'd0);
        chk({tag, "_rd"}, 64'(Rd_MEM), 64'd0);
        chk({tag, "_regwrite"}, 64'(RegWrite_MEM), 64'd0);
        chk({tag, "_valid"}, 64'(valid_MEM), 64'd0);
        chk({tag, "_fault"}, 64'(fault_MEM), 64'd0);
    endtask

    initial begin
        logic [63:0] a;
        int          kind, lat;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = '0;
        for (int i = 0; i < 32; i++) begin
            model_mem[i] = {$urandom, $urandom};
            dev_mem[i]   = model_mem[i];
        end
        model_mem[8] = 64'hDEAD_BEEF;
        dev_mem[8]   = 64'hDEAD_BEEF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Directed sequence
        issue(64'h1234, 64'h0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        issue(64'h40, 64'h0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b1, 2);
        issue(64'h18, 64'hCAFE_F00D, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        issue(64'h99, 64'h0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        issue(64'h41, 64'h0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        issue(64'h20, 64'h0, 5'd10, 1'b0, 1'b1, 1'b1, 1'b1, 99);
        issue(64'h777, 64'h0, 5'd11, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        issue(64'h43, 64'h55, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        issue(64'h18, 64'h0, 5'd13, 1'b0, 1'b1, 1'b1, 1'b1, 1);

        // Random stream
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 4);
            a    = {$urandom, 16'h0, 8'($urandom_range(0, 31) << 3)};
            if ($urandom_range(0, 7) == 0) a[2:0] = 3'($urandom_range(1, 7));
            lat  = ($urandom_range(0, 7) == 0) ? TO + 2 : $urandom_range(0, 2);
            case (kind)
                0, 1: issue({$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom),
                            1'b0, 1'b0, 1'($urandom), 1'b1, 0);
                2:    issue(a, {$urandom, $urandom}, 5'($urandom), 1'b0, 1'b1, 1'b1, 1'b1, lat);
                3:    issue(a, {$urandom, $urandom}, 5'($urandom), 1'b1, 1'b0, 1'($urandom), 1'b1, lat);
                default: issue(a, {$urandom, $urandom}, 5'($urandom), 1'($urandom),
                               1'($urandom), 1'($urandom), 1'b0, 0);
            endcase
        end
        drain();

        // Reset during the second WAIT cycle of a load that never gets ready
        begin
            req_t q;
            q.addr  = 64'h48;
            q.we    = 1'b0;
            q.wdata = 64'h0;
            q.lat   = 99;
            ALUResult_EX = 64'h48;
            MemWrite_EX  = 1'b0;
            MemToReg_EX  = 1'b1;
            RegWrite_EX  = 1'b1;
            Rd_EX        = 5'd14;
            valid_EX     = 1'b1;
            req_q.push_back(q);
            @(posedge clk);
            #1;
            valid_EX = 1'b0;
            @(negedge clk);
            chk("rst_test_req_wait1", 64'(mif.mem_req), 64'd1);
            @(posedge clk);
            #1;
            reset = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_all_zero("midreset");
            @(posedge clk);
            #1;
            reset     = 1'b1;
            have_prev = 1'b0;
            req_q.delete();
        end
        issue(64'hABCD, 64'h0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
